pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (operands, immediates, PC, instruction).
REQ-002 Parameter CTRL_W, default 24: width of the packed control-bit payload (EX/MEM/WB controls).
REQ-003 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port flush, input, 1: synchronous kill of all held and incoming beats.
REQ-007 Port in_valid, input, 1: upstream beat present.
REQ-008 Port in_ready, output, 1: stage can accept a beat.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port in_ctrl, input, CTRL_W: upstream control bits.
REQ-011 Port out_valid, output, 1: downstream beat present.
REQ-012 Port out_ready, input, 1: downstream accepts beat.
REQ-013 Port out_data, output, DATA_W: held payload.
REQ-014 Port out_ctrl, output, CTRL_W: held control bits.
REQ-015 Port occupancy, output, 2: number of beats held (0..2).
REQ-016 Port stall_cnt, output, CNT_W: count of back-pressured cycles.

Function
REQ-017 Input fire = in_valid & in_ready & !flush; output fire = out_valid & out_ready.
REQ-018 Beats SHALL leave in arrival order; none duplicated or lost except by flush.
REQ-019 Minimum latency SHALL be 1 cycle: a beat accepted at edge N appears on out_* after edge N when the output entry is empty or firing.
REQ-020 Sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-021 out_data and out_ctrl SHALL read all-zero whenever out_valid=0 (bubble = NOP, all controls deasserted).
REQ-022 flush=1 SHALL, at the next edge, empty all entries (out_valid=0, occupancy=0) and discard any beat presented that cycle, regardless of in_ready; flush beats simultaneous in/out fire.
REQ-023 An output fire during a flush cycle SHALL still count as delivered to downstream; flush affects only state after the edge.
REQ-024 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-025 Simultaneous input fire and output fire with one beat held SHALL leave occupancy unchanged and replace the output beat with the next in order.

Reset
REQ-026 While rst_n=0, regardless of clk: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, and all internal entries empty.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 from the first edge after rst_n rises.
REQ-028 Reset asserted mid-transfer SHALL discard all held beats with no partial output.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN selects the buffering mode.
REQ-030 With PIPE_STAGE_SKID_EN defined: two entries (output + skid); in_ready driven directly from a flop, = skid entry empty; a beat arriving while out_ready=0 parks in the skid entry; skid drains into the output entry on the next output fire; occupancy reaches 2.
REQ-031 Without PIPE_STAGE_SKID_EN: one entry; in_ready = !out_valid | out_ready (combinational from out_ready); occupancy never exceeds 1.
REQ-032 REQ-017..028 SHALL hold in both modes.

Verification
REQ-033 Streaming: in_valid=1, out_ready=1, data 1,2,3,... for 10 cycles -> out_data 1..10 on consecutive cycles, 1-cycle latency, stall_cnt=0.
REQ-034 Backpressure (SKID mode): out_ready=0 while sending A,B -> occupancy=2, in_ready=0, out_data=A held; out_ready=1 -> A then B, no loss; stall_cnt equals held cycles.
REQ-035 Flush: occupancy=2, flush=1 with in_valid=1 data C -> next cycle out_valid=0, out_data=0, out_ctrl=0, occupancy=0; C never emerges.
REQ-036 Counter saturation, CNT_W=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
REQ-037 Async reset: assert rst_n=0 between edges with occupancy=1 -> outputs zero immediately; after release, first accepted beat emerges correctly.
REQ-038 Random valid/ready/flush, both macro settings, 10k cycles -> output sequence equals scoreboard of accepted minus flushed beats; out_* zero whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register for one datapath beat (payload + controls).
//
// Build option: PIPE_STAGE_SKID_EN
//   defined   -> two entries (output + skid); in_ready comes straight from a flop.
//   undefined -> one entry; in_ready = !out_valid | out_ready (combinational).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous kill of held and incoming beats
//   in_valid/in_ready    upstream handshake; in_data/in_ctrl upstream payload
//   out_valid/out_ready  downstream handshake; out_data/out_ctrl held payload (zero when idle)
//   occupancy            beats currently held (0..2)
//   stall_cnt            saturating count of back-pressured cycles
module pipe_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [1:0]        occ_q,       occ_d;
    logic [CNT_W-1:0]  stall_q,     stall_d;
    // Low through reset, high from the first edge after release.
    logic              rdy_q,       rdy_d;
    logic              in_fire;
    logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Registered ready: accept only while the skid entry is free.
    assign in_ready = rdy_q;
`else
    // Single entry can take a beat when empty or when the held beat leaves now.
    assign in_ready = rdy_q & (~out_valid_q | out_ready);
`endif

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid_q & out_ready;

    // Next-state for entries, occupancy, ready flop and stall counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        stall_d     = stall_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
`endif

        // Stall counting ignores flush: a refused beat is still a stalled cycle.
        if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_ctrl_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
`endif
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            if (!out_valid_q || out_fire) begin
                // Output slot frees up: skid beat is older, so it goes first.
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = skid_data_q;
                    out_ctrl_d   = skid_ctrl_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = '0;
                    skid_ctrl_d  = '0;
                end else if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_ctrl_d  = in_ctrl;
                end else begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_ctrl_d  = '0;
                end
            end else if (in_fire) begin
                // Output is stuck; park the new beat.
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
            end
`else
            if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_ctrl_d  = in_ctrl;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_ctrl_d  = '0;
            end
`endif
        end

`ifdef PIPE_STAGE_SKID_EN
        occ_d = {1'b0, out_valid_d} + {1'b0, skid_valid_d};
        rdy_d = ~skid_valid_d;
`else
        occ_d = {1'b0, out_valid_d};
        rdy_d = 1'b1;
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            occ_q       <= 2'd0;
            stall_q     <= '0;
            rdy_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            occ_q       <= occ_d;
            stall_q     <= stall_d;
            rdy_q       <= rdy_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; expectations cover both buffering modes.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 24;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_occ",       64'(occupancy), 64'd0);
        check("rst_stall",     64'(stall_cnt), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);

        // Release between edges: ready only rises at the next edge.
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", 64'(in_ready), 64'd0);
        tick();
        check("rdy_after_edge", 64'(in_ready), 64'd1);

        // Streaming 1..10 with 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            in_ctrl  = CTRL_W'(i * 3);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data",  64'(out_data),  64'(i));
            check("stream_ctrl",  64'(out_ctrl),  64'(i * 3));
            check("stream_occ",   64'(occupancy), 64'd1);
        end
        in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        tick();
        check("stream_end_valid", 64'(out_valid), 64'd0);
        check("stream_end_data",  64'(out_data),  64'd0);
        check("stream_end_occ",   64'(occupancy), 64'd0);
        check("stream_stall",     64'(stall_cnt), 64'd0);

        // Backpressure: A then B while out_ready=0.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00AA; in_ctrl = 24'h0000AA;
        tick();
        check("bp_a_data",  64'(out_data),  64'hAA);
        check("bp_a_occ",   64'(occupancy), 64'd1);
        check("bp_a_rdy",   64'(in_ready),  SKID ? 64'd1 : 64'd0);
        in_data = 32'h0000_00BB; in_ctrl = 24'h0000BB;
        tick();
        check("bp_b_occ",   64'(occupancy), SKID ? 64'd2 : 64'd1);
        check("bp_b_rdy",   64'(in_ready),  64'd0);
        check("bp_b_data",  64'(out_data),  64'hAA);
        check("bp_b_stall", 64'(stall_cnt), 64'd1);
        in_valid = 1'b0;
        tick();
        check("bp_hold_stall", 64'(stall_cnt), 64'd2);
        check("bp_hold_data",  64'(out_data),  64'hAA);
        check("bp_hold_ctrl",  64'(out_ctrl),  64'hAA);
        out_ready = 1'b1;
        tick();
        check("bp_drain_valid", 64'(out_valid), SKID ? 64'd1 : 64'd0);
        check("bp_drain_data",  64'(out_data),  SKID ? 64'hBB : 64'd0);
        check("bp_drain_stall", 64'(stall_cnt), 64'd2);
        tick();
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_empty_occ",   64'(occupancy), 64'd0);

        // Flush a full stage while C is offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 24'h11;
        tick();
        in_data = 32'h22; in_ctrl = 24'h22;
        tick();
        check("fl_pre_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
        flush = 1'b1; in_data = 32'hCC; in_ctrl = 24'hCC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_data",  64'(out_data),  64'd0);
        check("fl_ctrl",  64'(out_ctrl),  64'd0);
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_stall", 64'(stall_cnt), 64'd4);
        check("fl_rdy",   64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        check("fl_c_gone", 64'(out_valid), 64'd0);

        // Flush discards a beat even when the stage would accept it.
        in_valid = 1'b1; in_data = 32'hDD; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_d_gone", 64'(out_valid), 64'd0);
        check("fl_d_occ",  64'(occupancy), 64'd0);

        // Stall counter saturation (CNT_W=4).
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5A; in_ctrl = 24'h5A;
        tick();
        in_valid = 1'b0;
        check("sat_start", 64'(stall_cnt), 64'd4);
        repeat (10) tick();
        check("sat_14", 64'(stall_cnt), 64'd14);
        repeat (10) tick();
        check("sat_15",   64'(stall_cnt), 64'd15);
        check("sat_data", 64'(out_data),  64'h5A);
        tick();
        check("sat_hold", 64'(stall_cnt), 64'd15);
        check("sat_occ",  64'(occupancy), 64'd1);

        // Asynchronous reset between edges with one beat held.
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_data",  64'(out_data),  64'd0);
        check("ar_ctrl",  64'(out_ctrl),  64'd0);
        check("ar_occ",   64'(occupancy), 64'd0);
        check("ar_stall", 64'(stall_cnt), 64'd0);
        check("ar_rdy",   64'(in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        check("ar_rdy_up",   64'(in_ready),  64'd1);
        check("ar_no_stale", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 24'h77;
        tick();
        in_valid = 1'b0;
        check("ar_g_valid", 64'(out_valid), 64'd1);
        check("ar_g_data",  64'(out_data),  64'h77);
        check("ar_g_ctrl",  64'(out_ctrl),  64'h77);
        tick();
        check("ar_g_done", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
